// File: rtl/spi_arbiter_pkg.sv
// rtl/spi_arbiter_pkg.sv - shared types and widths for the SPI arbiter
package spi_arb_pkg;
   localparam int SPI_W = 16;
   localparam int SS_W  = 3;
   localparam int RD_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      DONE
   } arb_state_e;
endpackage

// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester and SPI-master side signals of the SPI arbiter
interface spi_arbiter_if
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]       req_wrt;
   logic [SPI_W*NUM_REQ-1:0] req_data;
   logic [SS_W*NUM_REQ-1:0]  req_ss;
   logic [NUM_REQ-1:0]       req_busy;
   logic [NUM_REQ-1:0]       req_done;
   logic [NUM_REQ-1:0]       req_tmo;
   logic [NUM_REQ-1:0]       req_ovf;
   logic [RD_W-1:0]          rd_data;
   logic [SPI_W-1:0]         SPI_data;
   logic [SS_W-1:0]          ss;
   logic                     wrt_SPI;
   logic                     SPI_done;
   logic [RD_W-1:0]          EEP_data;

   modport master (
      input  req_wrt, req_data, req_ss, SPI_done, EEP_data,
      output req_busy, req_done, req_tmo, req_ovf, rd_data, SPI_data, ss, wrt_SPI
   );

   modport slave (
      output req_wrt, req_data, req_ss, SPI_done, EEP_data,
      input  req_busy, req_done, req_tmo, req_ovf, rd_data, SPI_data, ss, wrt_SPI
   );
endinterface

// File: rtl/spi_arbiter_rr_pick.sv
// rtl/spi_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pending,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          any_valid
);
   // Walk the search order backwards so the earliest pending slot is assigned last and wins.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (pending[(int'(ptr) + k) % N]) begin
            grant     = IW'((int'(ptr) + k) % N);
            any_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - shares one SPI master between requesters with round-robin grant and timeout
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 4096,
   parameter int TO_W    = 12
) (
   input logic           clk,
   input logic           rst_n,
   spi_arbiter_if.master bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e         state, state_nxt;
   logic [NUM_REQ-1:0] pending;
   logic [SPI_W-1:0]   slot_data [NUM_REQ];
   logic [SS_W-1:0]    slot_ss   [NUM_REQ];
   logic [IW-1:0]      ptr, grant, pick;
   logic               any_valid;
   logic [TO_W-1:0]    to_cnt;
   logic               to_hit;
   logic [NUM_REQ-1:0] owner, occupied;

   logic [NUM_REQ-1:0] done_q, tmo_q, ovf_q;
   logic [RD_W-1:0]    rd_q;
   logic [SPI_W-1:0]   data_q;
   logic [SS_W-1:0]    ss_q;
   logic               wrt_q;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .pending   (pending),
      .ptr       (ptr),
      .grant     (pick),
      .any_valid (any_valid)
   );

   always_comb begin
      owner        = '0;
      owner[grant] = 1'b1;
   end

   // A slot stays occupied until its transaction leaves WAIT, so a request in the DONE cycle is accepted.
   assign occupied = pending | (((state == LAUNCH) || (state == WAIT)) ? owner : '0);
   assign to_hit   = (to_cnt == TO_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_valid) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = WAIT;
         WAIT:    if (bus.SPI_done || to_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         ptr     <= '0;
         grant   <= '0;
         to_cnt  <= '0;
         done_q  <= '0;
         tmo_q   <= '0;
         ovf_q   <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         ss_q    <= '0;
         wrt_q   <= 1'b0;
      end else begin
         wrt_q  <= 1'b0;
         done_q <= '0;
         tmo_q  <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_wrt[i]) begin
               if (occupied[i]) ovf_q[i]   <= 1'b1;
               else             pending[i] <= 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant  <= pick;
                  ptr    <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                  data_q <= slot_data[pick];
                  ss_q   <= slot_ss[pick];
                  wrt_q  <= 1'b1;
               end
            end
            LAUNCH: to_cnt <= '0;
            WAIT: begin
               // SPI_done takes priority over a timeout landing in the same cycle.
               if (bus.SPI_done) begin
                  rd_q           <= bus.EEP_data;
                  pending[grant] <= 1'b0;
                  done_q         <= owner;
               end else if (to_hit) begin
                  pending[grant] <= 1'b0;
                  done_q         <= owner;
                  tmo_q          <= owner;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.req_wrt[i] && !occupied[i]) begin
            slot_data[i] <= bus.req_data[SPI_W*i +: SPI_W];
            slot_ss[i]   <= bus.req_ss[SS_W*i +: SS_W];
         end
      end
   end

   assign bus.req_busy = pending | ((state != IDLE) ? owner : '0);
   assign bus.req_done = done_q;
   assign bus.req_tmo  = tmo_q;
   assign bus.req_ovf  = ovf_q;
   assign bus.rd_data  = rd_q;
   assign bus.SPI_data = data_q;
   assign bus.ss       = ss_q;
   assign bus.wrt_SPI  = wrt_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - self-checking bench for spi_arbiter against a slot/queue reference model
module tb_spi_arbiter;
   import spi_arb_pkg::*;

   localparam int N   = 3;
   localparam int TMO = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_arbiter_if #(.NUM_REQ(N)) bus ();

   spi_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO), .TO_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: one buffered request per requester plus the transaction currently on the wire.
   bit          m_valid [N];
   logic [15:0] m_data  [N];
   logic [2:0]  m_ss    [N];
   logic [N-1:0] m_ovf;
   int          m_ptr;
   int          m_owner;
   logic [7:0]  m_rd;
   logic [15:0] cur_data;
   logic [2:0]  cur_ss;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_ovf   = '0;
      m_ptr   = 0;
      m_owner = -1;
      m_rd    = '0;
   endfunction

   function automatic void model_req(input int i, input logic [15:0] d, input logic [2:0] s);
      if (m_valid[i] || m_owner == i) m_ovf[i] = 1'b1;
      else begin
         m_valid[i] = 1'b1;
         m_data[i]  = d;
         m_ss[i]    = s;
      end
   endfunction

   function automatic int model_pick();
      for (int k = 0; k < N; k++)
         if (m_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] model_busy();
      logic [N-1:0] b;
      for (int i = 0; i < N; i++) b[i] = m_valid[i] || (m_owner == i);
      return b;
   endfunction

   task automatic drive(input logic [N-1:0] mask, input logic [16*N-1:0] d, input logic [3*N-1:0] s);
      bus.req_data = d;
      bus.req_ss   = s;
      bus.req_wrt  = mask;
      for (int i = 0; i < N; i++)
         if (mask[i]) model_req(i, d[16*i +: 16], s[3*i +: 3]);
      @(negedge clk);
      bus.req_wrt = '0;
   endtask

   task automatic drive_rand(input logic [N-1:0] mask);
      logic [16*N-1:0] d;
      logic [3*N-1:0]  s;
      for (int i = 0; i < N; i++) begin
         d[16*i +: 16] = 16'($urandom);
         s[3*i +: 3]   = 3'($urandom);
      end
      drive(mask, d, s);
   endtask

   task automatic wait_launch(input int exp_lat, input string tag);
      int n = 0;
      int g;
      do begin
         @(negedge clk);
         n++;
      end while (bus.wrt_SPI !== 1'b1 && n < 60);
      g = model_pick();
      check({tag, " launch"}, 64'(bus.wrt_SPI), 64'(g >= 0));
      if (bus.wrt_SPI !== 1'b1 || g < 0) return;
      if (exp_lat > 0) check({tag, " latency"}, 64'(n), 64'(exp_lat));
      check({tag, " SPI_data"}, 64'(bus.SPI_data), 64'(m_data[g]));
      check({tag, " ss"}, 64'(bus.ss), 64'(m_ss[g]));
      cur_data   = m_data[g];
      cur_ss     = m_ss[g];
      m_valid[g] = 1'b0;
      m_owner    = g;
      m_ptr      = (g + 1) % N;
   endtask

   task automatic finish_txn(input int delay, input logic [7:0] eep);
      logic [N-1:0] exp_done;
      for (int k = 0; k < delay; k++) begin
         @(negedge clk);
         check("hold SPI_data", 64'(bus.SPI_data), 64'(cur_data));
         check("hold ss", 64'(bus.ss), 64'(cur_ss));
         check("wrt_SPI low in WAIT", 64'(bus.wrt_SPI), 64'(0));
         check("busy in WAIT", 64'(bus.req_busy), 64'(model_busy()));
      end
      exp_done     = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      bus.SPI_done = 1'b1;
      bus.EEP_data = eep;
      @(negedge clk);
      bus.SPI_done = 1'b0;
      bus.EEP_data = 8'($urandom);
      check("req_done", 64'(bus.req_done), 64'(exp_done));
      check("req_tmo clear", 64'(bus.req_tmo), 64'(0));
      check("rd_data", 64'(bus.rd_data), 64'(eep));
      check("req_ovf", 64'(bus.req_ovf), 64'(m_ovf));
      m_rd    = eep;
      m_owner = -1;
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {bus.req_busy, bus.req_done, bus.req_tmo, bus.req_ovf, bus.rd_data,
                  bus.SPI_data, bus.ss, bus.wrt_SPI}, 64'(0));
   endtask

   initial begin
      int n;
      int first;
      bus.req_wrt  = '0;
      bus.req_data = '0;
      bus.req_ss   = '0;
      bus.SPI_done = 1'b0;
      bus.EEP_data = '0;
      model_reset();

      repeat (3) @(negedge clk);
      check_all_zero("reset outputs");
      rst_n = 1'b1;
      @(negedge clk);

      // Single request with known data.
      drive(3'b001, {32'h0, 16'hC0A5}, {6'h0, 3'b001});
      wait_launch(1, "single");
      finish_txn(3, 8'h3C);

      // All three at once, then a partial re-request.
      drive_rand(3'b111);
      for (int t = 0; t < 3; t++) begin
         wait_launch((t == 0) ? 1 : 2, "burst");
         finish_txn(1 + t, 8'($urandom));
      end
      @(negedge clk);
      drive_rand(3'b101);
      wait_launch(1, "rerequest");
      finish_txn(2, 8'($urandom));
      wait_launch(2, "rerequest");
      finish_txn(2, 8'($urandom));

      // Overflow while requester 1 is in flight.
      @(negedge clk);
      drive_rand(3'b010);
      wait_launch(1, "ovf");
      drive_rand(3'b010);
      drive_rand(3'b010);
      check("ovf sticky set", 64'(bus.req_ovf), 64'(3'b010));
      finish_txn(1, 8'($urandom));
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.wrt_SPI === 1'b1) n++;
      end
      check("single launch for ovf", 64'(n), 64'(0));
      check("ovf still set", 64'(bus.req_ovf), 64'(m_ovf));

      // Timeout on requester 2.
      drive_rand(3'b100);
      wait_launch(1, "timeout");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.req_done === '0 && n < 40);
      check("timeout latency", 64'(n), 64'(TMO + 1));
      check("timeout done", 64'(bus.req_done), 64'(3'b100));
      check("timeout tmo", 64'(bus.req_tmo), 64'(3'b100));
      check("timeout rd_data kept", 64'(bus.rd_data), 64'(m_rd));
      m_owner = -1;

      // Stray SPI_done in IDLE and in LAUNCH.
      @(negedge clk);
      bus.SPI_done = 1'b1;
      @(negedge clk);
      bus.SPI_done = 1'b0;
      check("stray idle done", 64'(bus.req_done), 64'(0));
      check("stray idle wrt", 64'(bus.wrt_SPI), 64'(0));
      check("stray idle busy", 64'(bus.req_busy), 64'(0));
      drive_rand(3'b001);
      wait_launch(1, "stray");
      bus.SPI_done = 1'b1;
      @(negedge clk);
      bus.SPI_done = 1'b0;
      check("stray launch done", 64'(bus.req_done), 64'(0));
      finish_txn(2, 8'($urandom));

      // Randomized rounds with requests injected in WAIT and in the DONE cycle.
      for (int r = 0; r < 25; r++) begin
         @(negedge clk);
         drive_rand(3'($urandom_range(1, 7)));
         first = 1;
         n     = 0;
         while (model_pick() >= 0 && n < 20) begin
            wait_launch((first == 1) ? 1 : 2, "random");
            first = 0;
            if ($urandom_range(0, 2) == 0) drive_rand(3'($urandom_range(1, 7)));
            finish_txn($urandom_range(1, 8), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
               drive_rand(3'($urandom_range(1, 7)));
               first = 1;
            end
            n++;
         end
      end

      // Reset during WAIT with two other slots pending.
      @(negedge clk);
      drive_rand(3'b100);
      wait_launch(1, "reset");
      drive_rand(3'b111 & ~(3'b001 << m_owner));
      #2 rst_n = 1'b0;
      #1 check_all_zero("async reset outputs");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.wrt_SPI !== 1'b0 || bus.req_done !== '0 || bus.req_busy !== '0) n++;
      end
      check("quiet after reset", 64'(n), 64'(0));

      // Fresh pointer serves 0, 1, 2 in order.
      drive_rand(3'b111);
      for (int t = 0; t < 3; t++) begin
         wait_launch((t == 0) ? 1 : 2, "post reset");
         check("post reset order", 64'(m_owner), 64'(t));
         finish_txn(1, 8'($urandom));
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
Shares the single SPI master between several requesters: the command/config block, the dump state machine and a spare calibration/EEPROM requester.
- Buffers one pending transaction per requester.
- Grants access round-robin and launches exactly one wrt_SPI pulse per transaction.
- Holds SPI_data and ss stable for the whole transaction.
- Routes SPI_done and the returned EEP byte back to the owning requester.
- Aborts hung transactions with a timeout.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = command/config, 1 = dump SM, 2 = spare)
TIMEOUT, 4096, cycles in WAIT without SPI_done before abort
TO_W, 12, width of the timeout counter (must hold TIMEOUT-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_wrt  in  NUM_REQ  one-cycle request pulse per requester
req_data  in  16*NUM_REQ  SPI word per requester, slice i = [16i+15:16i]
req_ss  in  3*NUM_REQ  slave select per requester, slice i = [3i+2:3i]
req_busy  out  NUM_REQ  slot i pending or in flight
req_done  out  NUM_REQ  one-cycle completion pulse to requester i
req_tmo  out  NUM_REQ  pulses with req_done when transaction i timed out
req_ovf  out  NUM_REQ  sticky; request i dropped because its slot was occupied
rd_data  out  8  EEP byte captured at completion
SPI_data  out  16  to SPI master
ss  out  3  to SPI master
wrt_SPI  out  1  one-cycle transaction start
SPI_done  in  1  from SPI master
EEP_data  in  8  MISO byte from SPI master

Behaviour:
Reset:
- All outputs 0; ss=3'b000; state IDLE.
- All slots empty; rr pointer=0; timeout counter=0.

Slots:
- req_wrt[i] with slot i empty captures req_data/req_ss slice i into slot i and sets pending[i] on that edge.
- req_wrt[i] with slot i occupied (pending or granted): request dropped, req_ovf[i] set; it clears only on reset.
- req_busy[i] = pending[i] | (granted to i and state != IDLE).

Round-robin:
- Search order is ptr, ptr+1, ..., wrapping mod NUM_REQ; the first pending slot wins.
- After a grant to g, ptr = (g+1) mod NUM_REQ.

FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE: if any slot is pending, latch grant g, and load SPI_data and ss from slot g; go to LAUNCH.
  - A request arriving in IDLE is visible next cycle, so the LAUNCH state is entered 2 cycles after req_wrt.
- LAUNCH: wrt_SPI=1 for exactly this cycle; timeout counter cleared; go to WAIT.
- WAIT:
  - SPI_done=1: capture rd_data=EEP_data, clear pending[g]; go to DONE.
  - Counter reaches TIMEOUT-1: clear pending[g], set the timeout flag; go to DONE, rd_data unchanged.
  - SPI_done and timeout in the same cycle: SPI_done wins, no timeout.
- DONE: req_done[g]=1 for one cycle, and req_tmo[g]=1 if the transaction timed out; go to IDLE.
  - Earliest next wrt_SPI is 3 cycles after SPI_done.

Output stability:
- SPI_data and ss change only on the IDLE->LAUNCH edge and otherwise hold their last values, including while idle.
- wrt_SPI is never high outside LAUNCH.

Boundary conditions:
- SPI_done outside WAIT is ignored.
- A new req_wrt[i] in the same cycle as req_done[i] is accepted, because the slot is already clear.
- Simultaneous requests from all requesters are all buffered and served in rr order, one transaction each.
- Reset mid-transaction returns to IDLE immediately and discards all slots; no req_done is issued.

All outputs are registered except req_busy.

Decomposition:
Package spi_arb_pkg:
- State enum (IDLE, LAUNCH, WAIT, DONE).
- Constants SPI_W=16, SS_W=3, RD_W=8.

Sub-module rr_pick:
- Combinational round-robin picker.
- Inputs: pending vector, ptr.
- Outputs: grant index, any_valid.
- Reused later by the other shared-resource arbiters.

Test Plan:
1. Single request: req_wrt[0] with data 16'hC0A5, ss 3'b001 -> wrt_SPI pulse 2 cycles later, SPI_data=C0A5, ss=001 stable until DONE. SPI_done with EEP_data=8'h3C -> req_done[0] next cycle, rd_data=3C.
2. Simultaneous requests: req_wrt=3'b111 in one cycle -> three transactions in order 0,1,2 with matching data/ss. Then re-request 3'b101 -> order 2,0 (ptr=0 after 2... verify 0 then 2 given ptr=0).
3. Overflow: req_wrt[1] twice while slot 1 is in WAIT -> second request dropped, req_ovf[1]=1 and sticky, exactly one wrt_SPI for requester 1.
4. Timeout: TIMEOUT=16, no SPI_done -> req_done[2] and req_tmo[2] high in the same cycle, 17 cycles after wrt_SPI; rd_data unchanged.
5. Stray done: SPI_done pulsed in IDLE and in LAUNCH -> no req_done, no state change.
6. Reset: rst_n low during WAIT with slots 0 and 1 pending -> all outputs 0, no further wrt_SPI after release until a new request.
